// File: rtl/prio_enc_hs.sv
// prio_enc_hs: registered, parametrised active-low priority encoder with a
// valid/ready output handshake.
//
// Samples WIDTH active-low request lines every cycle and grants the
// highest-index unmasked pending request. A granted code is held on out_N
// until the consumer accepts it (valid && ready at CLK). Further grants can
// follow back-to-back without an idle cycle.
//
// Optional feature (compile-time macro EDGE_LATCH_EN):
//   defined   - each request bit is latched on its falling edge into a sticky
//               pending bit that clears only when that index is accepted.
//   undefined - level mode: a request is pending while its line is held low.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   EI_N   in   enable in, active low; 1 blocks new grants and aborts a grant
//   in_N   in   [WIDTH-1:0] request lines, active low, bit WIDTH-1 highest
//   mask   in   [WIDTH-1:0] 1 = request excluded from selection
//   out_N  out  [CODE_W-1:0] granted index, active low (~idx)
//   GS_N   out  group select, active low, equals ~valid
//   EO_N   out  enable out, active low; 0 = enabled, idle, nothing eligible
//   valid  out  out_N holds a granted code
//   ready  in   consumer accepts the code when valid && ready at CLK
module prio_enc_hs #(
    parameter int unsigned  WIDTH  = 8,
    localparam int unsigned CODE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EI_N,
    input  logic [WIDTH-1:0]  in_N,
    input  logic [WIDTH-1:0]  mask,
    output logic [CODE_W-1:0] out_N,
    output logic              GS_N,
    output logic              EO_N,
    output logic              valid,
    input  logic              ready
);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  in_q;
    logic [CODE_W-1:0] out_q;
    logic              valid_q;
    logic              eo_q;

    logic [WIDTH-1:0]  pend;
    logic [WIDTH-1:0]  elig;
    logic [WIDTH-1:0]  elig_next;
    logic [WIDTH-1:0]  acc_oh;
    logic [CODE_W-1:0] idx;
    logic [CODE_W-1:0] idx_next;
    logic              any_elig;
    logic              any_next;
    logic              accept;

    // Highest set bit wins; later loop iterations overwrite earlier ones.
    function automatic logic [CODE_W-1:0] top_idx(input logic [WIDTH-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v[i]) begin
                r = CODE_W'(i);
            end
        end
        return r;
    endfunction

    assign accept = valid_q & ready;
    // One-hot of the index currently presented (out_N is its complement).
    assign acc_oh = {{(WIDTH-1){1'b0}}, 1'b1} << (~out_q);

`ifdef EDGE_LATCH_EN
    logic [WIDTH-1:0] in_qq;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] fall;

    assign fall = in_qq & ~in_q;
    // A fresh falling edge is visible to selection in the same cycle it is seen.
    assign pend = pend_q | fall;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_qq  <= '1;
            pend_q <= '0;
        end else begin
            in_qq  <= in_q;
            // Set wins over clear when both hit the same bit.
            pend_q <= (pend_q & ~(accept ? acc_oh : '0)) | fall;
        end
    end
`else
    assign pend = ~in_q;
`endif

    assign elig      = pend & ~mask;
    assign any_elig  = |elig;
    assign idx       = top_idx(elig);
    // Candidates for a back-to-back reload exclude the index being accepted.
    assign elig_next = elig & ~acc_oh;
    assign any_next  = |elig_next;
    assign idx_next  = top_idx(elig_next);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            in_q    <= '1;
            state_q <= StIdle;
            out_q   <= '1;
            valid_q <= 1'b0;
            eo_q    <= 1'b1;
        end else begin
            in_q <= in_N;
            eo_q <= (state_q != StIdle) || EI_N || any_elig;
            case (state_q)
                StIdle: begin
                    if (!EI_N && any_elig) begin
                        state_q <= StGrant;
                        out_q   <= ~idx;
                        valid_q <= 1'b1;
                    end
                end
                StGrant: begin
                    if (EI_N) begin
                        state_q <= StIdle;
                        out_q   <= '1;
                        valid_q <= 1'b0;
                    end else if (accept) begin
                        if (any_next) begin
                            out_q <= ~idx_next;
                        end else begin
                            state_q <= StIdle;
                            out_q   <= '1;
                            valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    out_q   <= '1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_N = out_q;
    assign valid = valid_q;
    assign GS_N  = ~valid_q;
    assign EO_N  = eo_q;

endmodule

// File: tb/tb_prio_enc_hs.sv
// Self-checking bench for prio_enc_hs: an 8-wide and a 16-wide instance.
// Expected grant codes are queued when requests are driven and compared as
// each code is accepted; state and flag checks are made directly.
module tb_prio_enc_hs;

    logic        clk;
    logic        rst_n;

    logic        ei8;
    logic [7:0]  in8;
    logic [7:0]  mask8;
    logic        ready8;
    logic [2:0]  out8;
    logic        gs8;
    logic        eo8;
    logic        valid8;

    logic        ei16;
    logic [15:0] in16;
    logic [15:0] mask16;
    logic        ready16;
    logic [3:0]  out16;
    logic        gs16;
    logic        eo16;
    logic        valid16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] q8[$];
    logic [3:0] q16[$];

    prio_enc_hs #(.WIDTH(8)) u_dut8 (
        .CLK   (clk),
        .RST_N (rst_n),
        .EI_N  (ei8),
        .in_N  (in8),
        .mask  (mask8),
        .out_N (out8),
        .GS_N  (gs8),
        .EO_N  (eo8),
        .valid (valid8),
        .ready (ready8)
    );

    prio_enc_hs #(.WIDTH(16)) u_dut16 (
        .CLK   (clk),
        .RST_N (rst_n),
        .EI_N  (ei16),
        .in_N  (in16),
        .mask  (mask16),
        .out_N (out16),
        .GS_N  (gs16),
        .EO_N  (eo16),
        .valid (valid16),
        .ready (ready16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Codes are compared on the cycle they are accepted.
    always @(negedge clk) begin
        if (rst_n && valid8 && ready8) begin
            if (q8.size() == 0) check_eq("sb8_extra", q8.size(), 1);
            else check_eq("sb8_grant", out8, q8.pop_front());
        end
        if (rst_n && valid16 && ready16) begin
            if (q16.size() == 0) check_eq("sb16_extra", q16.size(), 1);
            else check_eq("sb16_grant", out16, q16.pop_front());
        end
    end

    initial begin
        rst_n   = 1'b1;
        ei8     = 1'b0;
        in8     = 8'hFF;
        mask8   = 8'h00;
        ready8  = 1'b0;
        ei16    = 1'b0;
        in16    = 16'hFFFF;
        mask16  = 16'h0000;
        ready16 = 1'b0;

        // Reset, then idle
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_out", out8, 3'b111);
        check_eq("rst_valid", valid8, 0);
        check_eq("rst_gs", gs8, 1);
        check_eq("rst_eo", eo8, 1);
        #15 rst_n = 1'b1;
        tick();
        check_eq("idle_out", out8, 3'b111);
        check_eq("idle_valid", valid8, 0);
        check_eq("idle_gs", gs8, 1);
        check_eq("idle_eo", eo8, 0);

        // Single request on bit 2: two-clock latency, held while ready = 0
        in8 = 8'hFB;
        q8.push_back(3'b101);
        tick();
        check_eq("lat_valid_early", valid8, 0);
        tick();
        check_eq("single_valid", valid8, 1);
        check_eq("single_out", out8, 3'b101);
        check_eq("single_gs", gs8, 0);
        check_eq("single_eo", eo8, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_out", out8, 3'b101);
        end

        // Higher-priority arrival ignored until accept, then back-to-back
        in8 = 8'hBB;
        q8.push_back(3'b001);
        tick();
        tick();
        check_eq("hold_hi_out", out8, 3'b101);
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        check_eq("b2b_valid", valid8, 1);
        check_eq("b2b_out", out8, 3'b001);
        in8 = 8'hFF;
        tick();
        tick();
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        check_eq("done_valid", valid8, 0);
        check_eq("done_out", out8, 3'b111);
        tick();
        check_eq("done_eo", eo8, 0);

        // Masked request: no grant, EO_N low
        mask8 = 8'h80;
        in8   = 8'h7F;
        tick();
        tick();
        tick();
        check_eq("mask_valid", valid8, 0);
        check_eq("mask_eo", eo8, 0);
        in8 = 8'hFF;
        tick();
        tick();
        mask8 = 8'h00;
`ifdef EDGE_LATCH_EN
        // Sticky bit survived the mask and is granted once unmasked
        q8.push_back(3'b000);
        tick();
        check_eq("unmask_valid", valid8, 1);
        check_eq("unmask_out", out8, 3'b000);
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        check_eq("unmask_done", valid8, 0);
`else
        tick();
        check_eq("unmask_valid", valid8, 0);
        check_eq("unmask_eo", eo8, 0);
`endif
        tick();

        // EI_N abort during grant; pending request survives
        in8 = 8'hEF;
        tick();
        tick();
        check_eq("ab_pre_out", out8, 3'b011);
        ei8 = 1'b1;
        tick();
        check_eq("abort_valid", valid8, 0);
        check_eq("abort_out", out8, 3'b111);
        check_eq("abort_eo", eo8, 1);
        tick();
        check_eq("ei_hold_valid", valid8, 0);
        check_eq("ei_hold_eo", eo8, 1);
        ei8 = 1'b0;
        q8.push_back(3'b011);
        tick();
        check_eq("regrant_valid", valid8, 1);
        check_eq("regrant_out", out8, 3'b011);
        in8 = 8'hFF;
        tick();
        tick();
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        check_eq("regrant_done", valid8, 0);
        tick();
        tick();

        // One-cycle low pulses on bits 5 and 1
        in8 = 8'hDD;
        q8.push_back(3'b010);
`ifdef EDGE_LATCH_EN
        q8.push_back(3'b110);
`endif
        tick();
        in8 = 8'hFF;
        tick();
        check_eq("pulse_out", out8, 3'b010);
        ready8 = 1'b1;
        tick();
        tick();
        ready8 = 1'b0;
        tick();
        check_eq("pulse_valid", valid8, 0);
        check_eq("pulse_eo", eo8, 0);

        // WIDTH = 16: index 15, then index 0 after accept
        in16 = 16'h7FFE;
        q16.push_back(4'b0000);
        tick();
        tick();
        check_eq("w16_valid", valid16, 1);
        check_eq("w16_out", out16, 4'b0000);
        ready16 = 1'b1;
        in16    = 16'hFFFE;
        tick();
        ready16 = 1'b0;
        check_eq("w16_next_valid", valid16, 1);
        check_eq("w16_next_out", out16, 4'b1111);

        // Asynchronous reset mid-grant, between clock edges
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", valid16, 0);
        check_eq("arst_gs", gs16, 1);
        check_eq("arst_out", out16, 4'b1111);
        check_eq("arst_eo", eo16, 1);

        check_eq("sb8_drain", q8.size(), 0);
        check_eq("sb16_drain", q16.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
